// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encoding, lamp decode and default durations
package traffic_pkg;

    typedef enum logic [2:0] {
        GA    = 3'd0,
        YA    = 3'd1,
        RR_AB = 3'd2,
        GB    = 3'd3,
        YB    = 3'd4,
        RR_BA = 3'd5
    } phase_t;

    localparam int GREEN_MIN_DEF = 4;
    localparam int GREEN_MAX_DEF = 10;
    localparam int YELLOW_T_DEF  = 2;
    localparam int ALLRED_T_DEF  = 1;
    localparam int WALK_T_DEF    = 3;
    localparam int CNT_W_DEF     = 8;

    typedef struct packed {
        logic ra;
        logic ya;
        logic ga;
        logic rb;
        logic yb;
        logic gb;
    } lamps_t;

    // Unused encodings fall back to all-red so a road never sees two lamps.
    function automatic lamps_t lamps_of(input phase_t p);
        lamps_t l;
        case (p)
            GA:      l = '{ra: 1'b0, ya: 1'b0, ga: 1'b1, rb: 1'b1, yb: 1'b0, gb: 1'b0};
            YA:      l = '{ra: 1'b0, ya: 1'b1, ga: 1'b0, rb: 1'b1, yb: 1'b0, gb: 1'b0};
            GB:      l = '{ra: 1'b1, ya: 1'b0, ga: 1'b0, rb: 1'b0, yb: 1'b0, gb: 1'b1};
            YB:      l = '{ra: 1'b1, ya: 1'b0, ga: 1'b0, rb: 1'b0, yb: 1'b1, gb: 1'b0};
            default: l = '{ra: 1'b1, ya: 1'b0, ga: 1'b0, rb: 1'b1, yb: 1'b0, gb: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - per-phase cycle counter with clear, saturation and compares
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] lim,
    input  logic [CNT_W-1:0] floor_val,
    output logic [CNT_W-1:0] cnt,
    output logic             at_lim,
    output logic             at_floor
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt != lim) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_lim   = (cnt == lim);
    assign at_floor = (cnt >= floor_val);

endmodule

// File: rtl/traffic_phase_sched.sv
// rtl/traffic_phase_sched.sv - two-road traffic light phase scheduler with pedestrian walk
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = GREEN_MIN_DEF,
    parameter int GREEN_MAX = GREEN_MAX_DEF,
    parameter int YELLOW_T  = YELLOW_T_DEF,
    parameter int ALLRED_T  = ALLRED_T_DEF,
    parameter int WALK_T    = WALK_T_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sa,
    input  logic       sb,
    input  logic       pa,
    input  logic       pb,
    output logic       ra,
    output logic       ya,
    output logic       ga,
    output logic       rb,
    output logic       yb,
    output logic       gb,
    output logic       walk_a,
    output logic       walk_b,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] GMIN_L = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_L = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_L  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_L   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_L = CNT_W'(WALK_T - 1);

    phase_t           state;
    phase_t           nxt;
    lamps_t           lamps;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lim;
    logic             at_lim;
    logic             at_min;
    logic             at_walk;
    logic             pend_a;
    logic             pend_b;
    logic             dem_a;
    logic             dem_b;
    logic             enter_ga;
    logic             enter_gb;

    assign dem_a    = sa | pend_a;
    assign dem_b    = sb | pend_b;
    assign at_walk  = (cnt == WALK_L);
    assign enter_ga = (nxt == GA) && (state != GA);
    assign enter_gb = (nxt == GB) && (state != GB);

    // The saturation limit doubles as the exit compare for yellow and all-red.
    always_comb begin
        lim = AR_L;
        case (state)
            GA, GB:  lim = GMAX_L;
            YA, YB:  lim = YEL_L;
            default: lim = AR_L;
        endcase
    end

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (nxt != state),
        .lim      (lim),
        .floor_val(GMIN_L),
        .cnt      (cnt),
        .at_lim   (at_lim),
        .at_floor (at_min)
    );

    always_comb begin
        nxt = state;
        case (state)
            GA:      if (at_min && dem_b && (!sa || at_lim)) nxt = YA;
            YA:      if (at_lim) nxt = RR_AB;
            RR_AB:   if (at_lim) nxt = GB;
            GB:      if (at_min && dem_a && (!sb || at_lim)) nxt = YB;
            YB:      if (at_lim) nxt = RR_BA;
            RR_BA:   if (at_lim) nxt = GA;
            default: nxt = GA;
        endcase
    end

    // Lamps and walk are registered from the next state so they track state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= GA;
            lamps  <= lamps_of(GA);
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            walk_a <= 1'b0;
            walk_b <= 1'b0;
        end else begin
            state  <= nxt;
            lamps  <= lamps_of(nxt);
            pend_a <= enter_ga ? 1'b0 : (pend_a | pa);
            pend_b <= enter_gb ? 1'b0 : (pend_b | pb);
            walk_a <= enter_ga ? (pend_a | pa) : (walk_a && (nxt == GA) && !at_walk);
            walk_b <= enter_gb ? (pend_b | pb) : (walk_b && (nxt == GB) && !at_walk);
        end
    end

    assign {ra, ya, ga, rb, yb, gb} = lamps;
    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// tb/tb_traffic_phase_sched.sv - scoreboard bench for traffic_phase_sched
module tb_traffic_phase_sched;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst, sa, sb, pa, pb;
    logic       ra, ya, ga, rb, yb, gb, walk_a, walk_b;
    logic [2:0] phase;

    typedef struct {
        logic [2:0] ph;
        logic       wa;
        logic       wb;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    traffic_phase_sched dut (
        .clk   (clk),
        .rst   (rst),
        .sa    (sa),
        .sb    (sb),
        .pa    (pa),
        .pb    (pb),
        .ra    (ra),
        .ya    (ya),
        .ga    (ga),
        .rb    (rb),
        .yb    (yb),
        .gb    (gb),
        .walk_a(walk_a),
        .walk_b(walk_b),
        .phase (phase)
    );

    always #5 clk = ~clk;

    // Lamp table {ra,ya,ga,rb,yb,gb} for each phase code.
    function automatic logic [5:0] lamps_for(input logic [2:0] ph);
        case (ph)
            3'd0:    return 6'b001_100;
            3'd1:    return 6'b010_100;
            3'd3:    return 6'b100_001;
            3'd4:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic i_rst, input logic i_sa, input logic i_sb,
                       input logic i_pa, input logic i_pb,
                       input logic [2:0] ph, input logic wa, input logic wb,
                       input string tag);
        exp_t e;
        @(negedge clk);
        rst = i_rst; sa = i_sa; sb = i_sb; pa = i_pa; pb = i_pb;
        e.ph = ph; e.wa = wa; e.wb = wb; e.tag = tag;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [10:0] got;
        logic [10:0] want;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e    = q.pop_front();
                got  = {phase, ra, ya, ga, rb, yb, gb, walk_a, walk_b};
                want = {e.ph, lamps_for(e.ph), e.wa, e.wb};
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL %s: got phase/lamps/walk %b, expected %b", e.tag, got, want);
                end
                n_cmp++;
                if ($countones({ra, ya, ga}) != 1 || $countones({rb, yb, gb}) != 1) begin
                    n_bad++;
                    $display("FAIL one_lamp(%s): got A=%b B=%b, expected one-hot", e.tag,
                             {ra, ya, ga}, {rb, yb, gb});
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1; sa = 1'b0; sb = 1'b0; pa = 1'b0; pb = 1'b0;

        // Reset held two cycles.
        cyc(1, 0, 0, 0, 0, GA, 0, 0, "reset1");
        cyc(1, 0, 0, 0, 0, GA, 0, 0, "reset2");

        // Release with B demand only: 4 GA, 2 YA, 1 RR, GB on the 8th cycle.
        cyc(0, 0, 1, 0, 0, GA,    0, 0, "rel_ga2");
        cyc(0, 0, 1, 0, 0, GA,    0, 0, "rel_ga3");
        cyc(0, 0, 1, 0, 0, GA,    0, 0, "rel_ga4");
        cyc(0, 0, 1, 0, 0, YA,    0, 0, "rel_ya1");
        cyc(0, 0, 1, 0, 0, YA,    0, 0, "rel_ya2");
        cyc(0, 0, 1, 0, 0, RR_AB, 0, 0, "rel_rr");
        cyc(0, 0, 1, 0, 0, GB,    0, 0, "rel_gb");

        // Both sensors held: each green lasts GREEN_MAX cycles, alternating.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 9; i++)
                cyc(0, 1, 1, 0, 0, (r % 2 == 0) ? GB : GA, 0, 0, "max_green");
            cyc(0, 1, 1, 0, 0, (r % 2 == 0) ? YB : YA, 0, 0, "max_yel1");
            cyc(0, 1, 1, 0, 0, (r % 2 == 0) ? YB : YA, 0, 0, "max_yel2");
            cyc(0, 1, 1, 0, 0, (r % 2 == 0) ? RR_BA : RR_AB, 0, 0, "max_rr");
            cyc(0, 1, 1, 0, 0, (r % 2 == 0) ? GA : GB, 0, 0, "max_next");
        end

        // No demand at all: GA held indefinitely.
        cyc(1, 0, 0, 0, 0, GA, 0, 0, "idle_rst1");
        cyc(1, 0, 0, 0, 0, GA, 0, 0, "idle_rst2");
        for (int i = 0; i < 100; i++)
            cyc(0, 0, 0, 0, 0, GA, 0, 0, "idle_hold");

        // Pedestrian B pulse at GA cycle 2, re-press on GB entry edge.
        cyc(1, 0, 0, 0, 0, GA,    0, 0, "ped_rst");
        cyc(0, 0, 0, 0, 0, GA,    0, 0, "ped_c1");
        cyc(0, 0, 0, 0, 1, GA,    0, 0, "ped_press");
        cyc(0, 0, 0, 0, 0, GA,    0, 0, "ped_c3");
        cyc(0, 0, 0, 0, 0, YA,    0, 0, "ped_exit");
        cyc(0, 0, 0, 0, 0, YA,    0, 0, "ped_ya2");
        cyc(0, 0, 0, 0, 0, RR_AB, 0, 0, "ped_rr");
        cyc(0, 0, 0, 0, 1, GB,    0, 1, "ped_walk1");
        cyc(0, 0, 0, 0, 0, GB,    0, 1, "ped_walk2");
        cyc(0, 0, 0, 0, 0, GB,    0, 1, "ped_walk3");
        cyc(0, 0, 0, 0, 0, GB,    0, 0, "ped_walk_end");
        cyc(0, 0, 0, 0, 0, GB,    0, 0, "ped_gb_hold1");
        cyc(0, 0, 0, 0, 0, GB,    0, 0, "ped_gb_hold2");
        cyc(0, 1, 0, 0, 0, YB,    0, 0, "ped_a_demand");
        cyc(0, 0, 0, 0, 0, YB,    0, 0, "ped_yb2");
        cyc(0, 0, 0, 0, 0, RR_BA, 0, 0, "ped_rr_ba");
        cyc(0, 0, 0, 0, 0, GA,    0, 0, "ped_back_ga");
        for (int i = 0; i < 12; i++)
            cyc(0, 0, 0, 0, 0, GA, 0, 0, "ped_no_rerequest");

        // Reach the 2nd YB cycle with both flags pending, then reset.
        cyc(0, 0, 1, 0, 0, YA,    0, 0, "mid_ya1");
        cyc(0, 0, 1, 0, 0, YA,    0, 0, "mid_ya2");
        cyc(0, 0, 1, 0, 0, RR_AB, 0, 0, "mid_rr");
        cyc(0, 0, 1, 0, 0, GB,    0, 0, "mid_gb0");
        cyc(0, 1, 0, 1, 1, GB,    0, 0, "mid_press");
        cyc(0, 1, 0, 0, 0, GB,    0, 0, "mid_gb2");
        cyc(0, 1, 0, 0, 0, GB,    0, 0, "mid_gb3");
        cyc(0, 1, 0, 0, 0, YB,    0, 0, "mid_yb1");
        cyc(0, 0, 0, 0, 0, YB,    0, 0, "mid_yb2");
        cyc(1, 0, 0, 0, 0, GA,    0, 0, "mid_reset");
        for (int i = 0; i < 8; i++)
            cyc(0, 0, 0, 0, 0, GA, 0, 0, "mid_pend_cleared");

        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sched.md
TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

Interface
REQ-001 Parameter GREEN_MIN, default 4: minimum green cycles per road.
REQ-002 Parameter GREEN_MAX, default 10: maximum green cycles when the opposing road has demand.
REQ-003 Parameter YELLOW_T, default 2: yellow duration in cycles.
REQ-004 Parameter ALLRED_T, default 1: all-red clearance duration in cycles.
REQ-005 Parameter WALK_T, default 3: walk indication duration in cycles.
REQ-006 Parameter CNT_W, default 8: phase timer width; every duration parameter SHALL be in the range 1..2^CNT_W-1.
REQ-007 clk  in  1  sole clock; all state updates on the rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 sa, sb  in  1 each  vehicle sensors for road A and road B; level, sampled every cycle.
REQ-010 pa, pb  in  1 each  pedestrian buttons for road A and road B; pulses of any length.
REQ-011 ra, ya, ga  out  1 each  road A red/yellow/green lamps.
REQ-012 rb, yb, gb  out  1 each  road B red/yellow/green lamps.
REQ-013 walk_a, walk_b  out  1 each  pedestrian walk indication for road A and road B.
REQ-014 phase  out  3  current FSM state encoding, for observation only.

Function
REQ-015 FSM states and order: GA -> YA -> RR_AB -> GB -> YB -> RR_BA -> GA.
REQ-016 All outputs SHALL be decoded from registered state only; there is no combinational input-to-output path.
REQ-017 Per road, exactly one of r/y/g SHALL be 1 in every cycle.
REQ-018 In GA/YA the B lamps SHALL be red; in GB/YB the A lamps SHALL be red; in RR_* both roads SHALL be red.
REQ-019 The timer SHALL clear to 0 on every state transition and increment each cycle otherwise, saturating at GREEN_MAX-1 in the green states.
REQ-020 The pending flag pend_a (pend_b) SHALL set on any cycle with pa (pb) = 1.
REQ-021 Opposing demand is defined as dem_b = sb | pend_b (and dem_a = sa | pend_a).
REQ-022 Exit GA -> YA at the edge where timer >= GREEN_MIN-1 and dem_b and (!sa or timer == GREEN_MAX-1); GB is symmetric with the A/B roles swapped.
REQ-023 With no opposing demand, the block SHALL hold the green state indefinitely.
REQ-024 Yellow SHALL exit after exactly YELLOW_T cycles, i.e. at timer == YELLOW_T-1.
REQ-025 All-red SHALL exit after exactly ALLRED_T cycles, i.e. at timer == ALLRED_T-1.
REQ-026 On entry to GA, pend_a SHALL clear; walk_a asserts for the first WALK_T cycles of GA if pend_a or pa was 1 on the entry edge. The same rule applies to B.
REQ-027 If WALK_T exceeds the green duration, walk SHALL drop when the road leaves green.
REQ-028 A press arriving in the same cycle as the pending-clear for that road SHALL be consumed as served; it SHALL NOT re-set the pending flag.

Reset
REQ-029 While rst=1 at an edge: state = GA, timer = 0, pend_a = pend_b = 0.
REQ-030 Reset values: ga=1, rb=1, all other lamp outputs 0, walk_a=walk_b=0.
REQ-031 rst asserted mid-phase, including during yellow or all-red, SHALL take effect at the next edge with no clearance sequence.

Structure
REQ-032 Shared package traffic_pkg SHALL hold the state enum (GA, YA, RR_AB, GB, YB, RR_BA) and the default duration constants.
REQ-033 A single sub-module phase_timer SHALL provide the CNT_W counter with clear, saturate limit and terminal-compare outputs.

Verification
REQ-034 Apply rst for 2 cycles -> ga=1, rb=1, all else 0, phase=GA.
REQ-035 Release rst with sa=0, sb=1 -> 4 cycles ga, 2 cycles ya, 1 cycle all-red, then gb=1 on the 8th cycle after release.
REQ-036 Hold sa=sb=1 -> each green lasts exactly 10 cycles, and the sequence repeats A/B alternately.
REQ-037 Hold sa=sb=pa=pb=0 for 100 cycles after reset -> ga stays 1 throughout, and no yellow is ever driven.
REQ-038 Pulse pb for 1 cycle at cycle 2 in GA with sb=0 -> exit at cycle 4, and walk_b=1 for the first 3 GB cycles; pb pressed again on the GB entry edge -> no extra B phase is requested.
REQ-039 Assert rst during the 2nd YB cycle -> ga=1, rb=1 and pending flags cleared on the next cycle; the invariant of one lamp per road is checked every cycle throughout.
